cnt_mod_adj: RTL and testbench
==============================

# cnt_mod_adj

Parametrised modulo-N time-field counter with push-button adjust, hold-to-repeat and a tick-driven carry output. It generalises the fixed seconds counter so the same block serves the seconds (MODULO=60), minutes (60) and hours (24) fields of the clock datapath. Instances are cascaded by feeding `carry_out` of one field into `pulse_in` of the next.

## Interface
Parameters:
- `WIDTH`, 6: counter width; must satisfy MODULO ≤ 2^WIDTH.
- `MODULO`, 60: count range 0..MODULO-1; minimum 2.
- `REPEAT_DELAY`, 25_000_000: clk cycles a button must be held after its press before the first auto-repeat event; minimum 2.
- `REPEAT_RATE`, 5_000_000: clk cycles between subsequent auto-repeat events; minimum 2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `pulse_in` in 1: one-cycle count tick (1 s strobe or upstream carry).
- `increase` in 1: adjust-up button, active-low, already synchronised and debounced.
- `decrease` in 1: adjust-down button, active-low, already synchronised and debounced.
- `enable` in 1: gates counting, adjust and carry.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value to load.
- `cnt` out WIDTH: registered count.
- `carry_out` out 1: combinational one-cycle pulse on a tick-driven upward wrap.

## Operation
- Reset (`rst`=0 at a clk edge): `cnt`=0; both button-history registers = 1 (released); hold counter = 0; repeat state = IDLE. `carry_out` is 0 while `rst`=0.
- Press event: `increase` (or `decrease`) is 0 this cycle and its history register is 1. History registers update every cycle, regardless of `enable`, so re-enabling never produces a spurious press.
- Repeat FSM:
  - IDLE: on a press event of exactly one button, load the hold counter and go to DELAY.
  - DELAY: the first event fires REPEAT_DELAY cycles after the press event; then go to REPEAT.
  - REPEAT: one event every REPEAT_RATE cycles.
  - Release of that button, or both buttons low at the same time, returns the FSM to IDLE with no event in that cycle.
  - A new press event of the other button while in DELAY/REPEAT restarts the FSM from that press.
- Per-cycle net step = (`pulse_in`) + (inc press or inc repeat) − (dec press or dec repeat), range −1..+2. All sources are summed; none is dropped.
- Update, in priority order:
  - `load`=1: `cnt` ← `load_val`, or MODULO-1 if `load_val` ≥ MODULO. Ignores `enable`. Discards the step.
  - `enable`=0: `cnt` holds. The FSM still tracks the buttons, but its events are discarded.
  - Otherwise: `cnt` ← (`cnt` + step) mod MODULO, computed in WIDTH+2 bits. Downward wrap 0 → MODULO-1; +2 from MODULO-1 gives 1.
- `carry_out` = `enable` & ~`load` & `rst` & `pulse_in` & (`cnt` + step ≥ MODULO). A button-only wrap never carries.

## Timing
- `cnt` changes on the clk edge that samples the event; it is visible one cycle after the inputs.
- `carry_out` is asserted in the same cycle as the wrapping `pulse_in`, before `cnt` updates. This is combinational from `cnt`, `pulse_in`, `enable`, `load` and the button-event logic.
- The press event acts in the cycle the button is first sampled low. The first repeat event occurs REPEAT_DELAY cycles later, then one every REPEAT_RATE cycles.
- Reset mid-hold: the FSM returns to IDLE. A button still held low after reset generates a press event on the first cycle after reset deasserts, because history resets to 1.

## Test plan
Parameters for all cases: MODULO=60, WIDTH=6, REPEAT_DELAY=8, REPEAT_RATE=4.
- Tick wrap: preload 58, pulse_in at cycles 0 and 1 → `cnt` 59 then 0; `carry_out`=1 only in cycle 1.
- Simultaneous tick and press: `cnt`=58, pulse_in=1 and `increase` falls in the same cycle → `cnt`=0, `carry_out`=1. With `cnt`=59 → `cnt`=1, `carry_out`=1. At `cnt`=10, pulse_in plus a `decrease` press → `cnt`=10, `carry_out`=0.
- Button-only wrap: `cnt`=0, `decrease` press → 59, `carry_out`=0. `cnt`=59, `increase` press → 0, `carry_out`=0.
- Auto-repeat: hold `increase` low for 20 cycles from `cnt`=5 → increments at press cycles 0, 8, 12, 16 → `cnt`=9. Release → no further change. Pressing both buttons → no repeat.
- Load and enable: `load_val`=63 with `load`=1 and `enable`=0 → `cnt`=59. `enable`=0 with pulse_in and presses → `cnt` unchanged and `carry_out`=0. Button held across re-enable → no event at re-enable.
- Synchronous reset: assert `rst`=0 during the REPEAT state with `cnt`=30 → `cnt`=0 on the next edge, not before it. Holding `increase` through the end of reset → `cnt`=1 one cycle after `rst` rises.

Source files
------------

// File: rtl/cnt_mod_adj.sv
// Modulo-N time-field counter with push-button adjust, hold-to-repeat and tick carry.
// Cascade fields by feeding carry_out into the next instance's pulse_in.
module cnt_mod_adj #(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned MODULO       = 60,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             increase,
    input  logic             decrease,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             carry_out
);

    localparam int unsigned SW       = WIDTH + 2;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HW       = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold;
    logic [HW-1:0]   hold_nxt;
    logic            sel;
    logic            sel_nxt;
    logic            inc_hist;
    logic            dec_hist;
    logic            inc_press;
    logic            dec_press;
    logic            sel_low;
    logic            other_press;
    logic            both_low;
    logic            rep_ev;
    logic            inc_ev;
    logic            dec_ev;
    logic [SW-1:0]   up;
    logic [SW-1:0]   net;
    logic [SW-1:0]   wrapped;
    logic            under;
    logic            over;
    logic [WIDTH-1:0] cnt_nxt;

    // Press = first cycle sampled low; sel=0 tracks increase, sel=1 tracks decrease
    assign inc_press   = ~increase & inc_hist;
    assign dec_press   = ~decrease & dec_hist;
    assign both_low    = ~increase & ~decrease;
    assign sel_low     = sel ? ~decrease : ~increase;
    assign other_press = sel ? inc_press : dec_press;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            hold     <= '0;
            sel      <= 1'b0;
            inc_hist <= 1'b1;
            dec_hist <= 1'b1;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            sel      <= sel_nxt;
            inc_hist <= increase;
            dec_hist <= decrease;
            cnt      <= cnt_nxt;
        end
    end

    // Hold-to-repeat FSM; hold counts down to the next repeat event
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        sel_nxt   = sel;
        rep_ev    = 1'b0;
        case (state)
            IDLE: begin
                if (inc_press ^ dec_press) begin
                    state_nxt = DELAY;
                    sel_nxt   = dec_press;
                    hold_nxt  = HW'(REPEAT_DELAY - 1);
                end
            end
            DELAY, REPEAT: begin
                if (both_low) begin
                    state_nxt = IDLE;
                end else if (other_press) begin
                    state_nxt = DELAY;
                    sel_nxt   = ~sel;
                    hold_nxt  = HW'(REPEAT_DELAY - 1);
                end else if (!sel_low) begin
                    state_nxt = IDLE;
                end else if (hold == '0) begin
                    rep_ev    = 1'b1;
                    state_nxt = REPEAT;
                    hold_nxt  = HW'(REPEAT_RATE - 1);
                end else begin
                    hold_nxt  = hold - HW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign inc_ev = inc_press | (rep_ev & ~sel);
    assign dec_ev = dec_press | (rep_ev & sel);

    // Net step -1..+2 applied in WIDTH+2 bits; underflow only possible from 0 with no up-step
    always_comb begin
        up    = SW'(cnt) + SW'(pulse_in) + SW'(inc_ev);
        under = dec_ev && (up == '0);
        net   = up - SW'(dec_ev);
        over  = !under && (net >= SW'(MODULO));
        if (under) begin
            wrapped = SW'(MODULO - 1);
        end else if (over) begin
            wrapped = net - SW'(MODULO);
        end else begin
            wrapped = net;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = (SW'(load_val) >= SW'(MODULO)) ? WIDTH'(MODULO - 1) : load_val;
        end else if (enable) begin
            cnt_nxt = WIDTH'(wrapped);
        end
    end

    // Only tick-driven upward wraps propagate to the next field
    assign carry_out = enable & ~load & rst & pulse_in & over;

endmodule

// File: tb/tb_cnt_mod_adj.sv
// Directed bench for cnt_mod_adj (MODULO=60, REPEAT_DELAY=8, REPEAT_RATE=4).
module tb_cnt_mod_adj;

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       increase;
    logic       decrease;
    logic       enable;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] cnt;
    logic       carry_out;

    int compared;
    int mismatched;

    cnt_mod_adj #(
        .WIDTH(6),
        .MODULO(60),
        .REPEAT_DELAY(8),
        .REPEAT_RATE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulse_in),
        .increase(increase),
        .decrease(decrease),
        .enable(enable),
        .load(load),
        .load_val(load_val),
        .cnt(cnt),
        .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; checks that follow see
    // cnt from the last rising edge and carry_out for this cycle's inputs.
    task automatic step(input logic p, input logic i, input logic d,
                        input logic en = 1'b1, input logic r = 1'b1);
        @(negedge clk);
        rst      = r;
        pulse_in = p;
        increase = i;
        decrease = d;
        enable   = en;
        load     = 1'b0;
        #1;
    endtask

    task automatic do_load(input logic [5:0] v, input logic en = 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        pulse_in = 1'b0;
        increase = 1'b1;
        decrease = 1'b1;
        enable   = en;
        load     = 1'b1;
        load_val = v;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst      = 1'b0;
        pulse_in = 1'b0;
        increase = 1'b1;
        decrease = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        load_val = '0;

        // Reset
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);

        // Tick wrap from 58
        do_load(6'd58);
        step(1'b1, 1'b1, 1'b1);
        check("tick_c0_cnt", 32'(cnt), 32'd58);
        check("tick_c0_carry", 32'(carry_out), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        check("tick_c1_cnt", 32'(cnt), 32'd59);
        check("tick_c1_carry", 32'(carry_out), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        check("tick_wrap_cnt", 32'(cnt), 32'd0);
        check("tick_after_carry", 32'(carry_out), 32'd0);

        // Tick plus press in the same cycle
        do_load(6'd58);
        step(1'b1, 1'b0, 1'b1);
        check("tick_inc58_carry", 32'(carry_out), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        check("tick_inc58_cnt", 32'(cnt), 32'd0);
        do_load(6'd59);
        step(1'b1, 1'b0, 1'b1);
        check("tick_inc59_carry", 32'(carry_out), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        check("tick_inc59_cnt", 32'(cnt), 32'd1);
        do_load(6'd10);
        step(1'b1, 1'b1, 1'b0);
        check("tick_dec10_carry", 32'(carry_out), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("tick_dec10_cnt", 32'(cnt), 32'd10);

        // Button-only wraps never carry
        do_load(6'd0);
        step(1'b0, 1'b1, 1'b0);
        check("dec_wrap_carry", 32'(carry_out), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("dec_wrap_cnt", 32'(cnt), 32'd59);
        do_load(6'd59);
        step(1'b0, 1'b0, 1'b1);
        check("inc_wrap_carry", 32'(carry_out), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("inc_wrap_cnt", 32'(cnt), 32'd0);

        // Auto-repeat: events at held cycles 0, 8, 12, 16
        do_load(6'd5);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("repeat_k%0d", k), 32'(cnt),
                  32'(5 + int'(k >= 1) + int'(k >= 9) + int'(k >= 13) + int'(k >= 17)));
        end
        step(1'b0, 1'b1, 1'b1);
        check("repeat_end_cnt", 32'(cnt), 32'd9);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
        check("release_hold_cnt", 32'(cnt), 32'd9);

        // Both buttons held: presses cancel and no repeat follows
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0);
        check("both_held_cnt", 32'(cnt), 32'd9);
        step(1'b0, 1'b1, 1'b1);
        check("both_release_cnt", 32'(cnt), 32'd9);

        // Load clamps and ignores enable
        do_load(6'd63, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("load_clamp_cnt", 32'(cnt), 32'd59);
        check("disabled_carry", 32'(carry_out), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("disabled_carry_k%0d", k), 32'(carry_out), 32'd0);
        end
        check("disabled_cnt", 32'(cnt), 32'd59);
        // Re-enable while increase is still held (held cycle 9): no event
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("reenable_cnt", 32'(cnt), 32'd59);

        // Reset during REPEAT, then press regenerated after reset
        do_load(6'd28);
        step(1'b0, 1'b0, 1'b1);
        check("rst_pre_c0", 32'(cnt), 32'd28);
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, 1'b1);
        check("rst_pre_c9", 32'(cnt), 32'd30);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_not_before", 32'(cnt), 32'd30);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_applied", 32'(cnt), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("rst_release_cnt", 32'(cnt), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("rst_press_cnt", 32'(cnt), 32'd1);
        step(1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
